// File: rtl/uart_pkg.sv
// Shared UART definitions: arbiter FSM encoding and link constants.
package uart_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned BAUD   = 9600;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        ISSUE      = 2'd1,
        WAIT_BUSY  = 2'd2,
        WAIT_EMPTY = 2'd3
    } arb_state_e;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester side and uart_tx side of the shared-transmitter arbiter.
interface uart_tx_arbiter_if
    import uart_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4
);
    logic [NUM_REQ-1:0]        req;
    logic [BYTE_W*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]        req_last;
    logic [NUM_REQ-1:0]        ack;
    logic [NUM_REQ-1:0]        grant;
    logic                      tx_wr_en;
    logic [BYTE_W-1:0]         tx_byte;
    logic                      tx_empty;

    modport master (
        output req, req_data, req_last, tx_empty,
        input  ack, grant, tx_wr_en, tx_byte
    );

    modport slave (
        input  req, req_data, req_last, tx_empty,
        output ack, grant, tx_wr_en, tx_byte
    );
endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin pick: first set req bit at or above ptr, wrapping.
module rr_pick #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          valid,
    output logic [IW-1:0] idx
);
    int unsigned pos;

    // Scan from the farthest offset down so the nearest requester wins last.
    always_comb begin
        valid = |req;
        idx   = '0;
        pos   = 0;
        for (int off = int'(N) - 1; off >= 0; off--) begin
            pos = 32'(ptr) + 32'(off);
            if (pos >= N) pos = pos - N;
            if (req[IW'(pos)]) idx = IW'(pos);
        end
    end
endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, burst-holding arbiter sharing one uart_tx among NUM_REQ producers.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned MAX_BURST    = 16,
    parameter int unsigned BUSY_TIMEOUT = 8
) (
    input  logic             clk,
    input  logic             rst,
    uart_tx_arbiter_if.slave bus,
    output logic             busy,
    output logic             err
);
    localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CW = 8;
    localparam int unsigned TW = $clog2(BUSY_TIMEOUT + 1);

    arb_state_e        state, state_nxt;
    logic [IW-1:0]     idx, idx_nxt;
    logic [IW-1:0]     rr_ptr, rr_ptr_nxt;
    logic [IW-1:0]     pick_idx;
    logic              pick_valid;
    logic [CW-1:0]     count, count_nxt;
    logic [TW-1:0]     tmr, tmr_nxt;
    logic              last_seen, last_nxt;
    logic              err_nxt;
    logic [NUM_REQ-1:0] grant_nxt, ack_nxt;
    logic              wr_nxt;
    logic [BYTE_W-1:0] byte_nxt;

    rr_pick #(.N(NUM_REQ)) u_pick (
        .req   (bus.req),
        .ptr   (rr_ptr),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            idx          <= '0;
            rr_ptr       <= '0;
            count        <= '0;
            tmr          <= '0;
            last_seen    <= 1'b0;
            err          <= 1'b0;
            busy         <= 1'b0;
            bus.grant    <= '0;
            bus.ack      <= '0;
            bus.tx_wr_en <= 1'b0;
            bus.tx_byte  <= '0;
        end else begin
            state        <= state_nxt;
            idx          <= idx_nxt;
            rr_ptr       <= rr_ptr_nxt;
            count        <= count_nxt;
            tmr          <= tmr_nxt;
            last_seen    <= last_nxt;
            err          <= err_nxt;
            busy         <= (state_nxt != IDLE);
            bus.grant    <= grant_nxt;
            bus.ack      <= ack_nxt;
            bus.tx_wr_en <= wr_nxt;
            bus.tx_byte  <= byte_nxt;
        end
    end

    // Strobe, ack and byte are registered on the ISSUE edge, so they appear together.
    always_comb begin
        state_nxt  = state;
        idx_nxt    = idx;
        rr_ptr_nxt = rr_ptr;
        count_nxt  = count;
        tmr_nxt    = tmr;
        last_nxt   = last_seen;
        err_nxt    = err;
        grant_nxt  = bus.grant;
        ack_nxt    = '0;
        wr_nxt     = 1'b0;
        byte_nxt   = bus.tx_byte;

        unique case (state)
            IDLE: begin
                if (bus.tx_empty && pick_valid) begin
                    idx_nxt   = pick_idx;
                    grant_nxt = NUM_REQ'(1) << pick_idx;
                    count_nxt = '0;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                wr_nxt    = 1'b1;
                byte_nxt  = bus.req_data[BYTE_W*32'(idx) +: BYTE_W];
                ack_nxt   = NUM_REQ'(1) << idx;
                count_nxt = count + CW'(1);
                last_nxt  = bus.req_last[idx];
                tmr_nxt   = '0;
                state_nxt = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (!bus.tx_empty) begin
                    state_nxt = WAIT_EMPTY;
                end else if (tmr == TW'(BUSY_TIMEOUT - 1)) begin
                    err_nxt   = 1'b1;
                    state_nxt = WAIT_EMPTY;
                end else begin
                    tmr_nxt = tmr + TW'(1);
                end
            end
            WAIT_EMPTY: begin
                if (bus.tx_empty) begin
                    if (bus.req[idx] && !last_seen && (count < CW'(MAX_BURST))) begin
                        state_nxt = ISSUE;
                    end else begin
                        grant_nxt  = '0;
                        rr_ptr_nxt = (idx == IW'(NUM_REQ - 1)) ? '0 : idx + IW'(1);
                        state_nxt  = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one uart_tx instance between NUM_REQ byte producers (e.g. command responder, debug logger, status reporter) on the 100 MHz fabric clock.
- Grants are round-robin. A grant is held for a burst so that multi-byte messages are not interleaved on the serial line.
- Drives the uart_tx wr_en/byte inputs and paces itself off tx_empty.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- MAX_BURST, 16, maximum bytes per grant before a forced release (1..255).
- BUSY_TIMEOUT, 8, clock cycles allowed for tx_empty to fall after a write strobe.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  reset; asynchronous, active-low.
- req  in  NUM_REQ  per-requester "byte available"; held until acked.
- req_data  in  8*NUM_REQ  per-requester byte; requester i uses bits [8i+7:8i].
- req_last  in  NUM_REQ  marks req_data[i] as the final byte of its message.
- ack  out  NUM_REQ  one-cycle pulse; req_data[i] was taken this cycle.
- grant  out  NUM_REQ  one-hot owner of the transmitter; 0 when idle.
- tx_wr_en  out  1  to uart_tx wr_en; one-cycle pulse.
- tx_byte  out  8  to uart_tx byte; valid in the tx_wr_en cycle.
- tx_empty  in  1  from uart_tx; high = idle and able to accept a byte.
- busy  out  1  high whenever state != IDLE.
- err  out  1  sticky; set on write-strobe timeout, cleared only by reset.

Behaviour:
- Reset (rst low, async): state=IDLE; ack, grant, tx_wr_en, busy, err all 0; tx_byte=0; rr_ptr=0; burst count=0.
- States: IDLE, ISSUE, WAIT_BUSY, WAIT_EMPTY.
- IDLE:
  - If tx_empty=1 and |req: pick the winner by scanning from rr_ptr upward, wrapping modulo NUM_REQ.
  - Register its index, set grant one-hot, set count=0, go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE (exactly one cycle):
  - tx_wr_en=1, tx_byte=req_data[idx], ack[idx]=1.
  - count++; last_seen=req_last[idx].
  - Go to WAIT_BUSY.
- WAIT_BUSY:
  - Wait for tx_empty=0, then go to WAIT_EMPTY.
  - If tx_empty is still 1 after BUSY_TIMEOUT cycles: set err, go to WAIT_EMPTY.
- WAIT_EMPTY: wait for tx_empty=1. Then:
  - Continue the burst (go to ISSUE, grant unchanged) when req[idx]=1 AND last_seen=0 AND count<MAX_BURST.
  - Otherwise release: grant=0, rr_ptr=(idx+1) mod NUM_REQ, go to IDLE.
- Latency:
  - First byte: req rises in cycle N → tx_wr_en in cycle N+2 (1 cycle to register the grant, 1 to issue).
  - Back-to-back bytes in a burst: tx_wr_en fires the cycle after tx_empty returns to 1.
- Only the winner sees ack. Non-granted requesters hold req and data stable; their req is ignored until IDLE.
- Requester drops req mid-burst: release at the next WAIT_EMPTY exit. No partial byte is lost, since only acked bytes were sent.
- req_last=1 on the first byte gives a single-byte grant.
- MAX_BURST reached: forced release, even if req_last was never seen. The requester re-arbitrates later in round-robin order.
- Only one requester active: it is re-granted after every release. The IDLE cycle between grants is mandatory.
- Reset mid-operation: all state clears immediately and any in-flight byte is abandoned. uart_tx shares the same reset.
- At most one tx_wr_en is issued per tx_empty low→high cycle. tx_wr_en is never asserted while tx_empty=0.

Decomposition:
- Shared package uart_pkg holds:
  - state encoding (IDLE=2'd0, ISSUE=2'd1, WAIT_BUSY=2'd2, WAIT_EMPTY=2'd3);
  - the byte-width constant 8;
  - the baud constant 9600.
- One sub-module, rr_pick, is natural: combinational round-robin priority encoder (inputs req and ptr; outputs a valid flag and the index). It is reused later by the rx-side dispatcher.
- The counter, timeout and FSM stay in uart_tx_arbiter.

Test Plan:
- Single request: req[0]=1, data 8'hF0, last=1.
  - Exactly one tx_wr_en with tx_byte=F0; ack[0] one cycle; grant returns to 0.
  - Looped-back uart_rx yields byte F0; rr_ptr=1.
- Contention: req=4'b1011 held, every last=1, data 8'hA0+i.
  - Service order 0,1,3,0,1,3; grant is always one-hot.
  - Exactly one wr_en per byte, never while tx_empty=0.
- Burst lock: requester 2 sends 3 bytes 11,22,33 (last on 33) while req[0] is held.
  - Bytes go out 11,22,33 contiguously, then requester 0.
- MAX_BURST: set MAX_BURST=4, requester 1 streams with last=0 while req[2]=1.
  - Release after 4 acks; requester 2 is granted next.
- Timeout: stub tx_empty stuck at 1.
  - err rises BUSY_TIMEOUT cycles after tx_wr_en and stays 1.
  - The FSM is in WAIT_EMPTY and issues the next byte on the following cycle.
- Reset mid-byte: pull rst low during WAIT_EMPTY.
  - Same cycle: grant=0, busy=0, tx_wr_en=0, err=0.
  - After release, the first grant goes to the lowest index requesting (rr_ptr=0).
